// File: rtl/clock_pkg.sv
// Shared encodings for the digital clock: mode codes, button codes and the hh:mm:ss layout.
package clock_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned BTN_W   = 5;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned TIME_W  = 3 * FIELD_W;

  typedef enum logic [STATE_W-1:0] {
    ST_INITIAL_DELAY = 4'b0000,
    ST_FUNCTION_SET  = 4'b0001,
    ST_INITIAL_SETUP = 4'b0010,
    ST_CLEAR_SCREEN  = 4'b0011,
    ST_SETUP         = 4'b0100,
    ST_TIME_SET      = 4'b0101,
    ST_TZ_SET        = 4'b0110,
    ST_LINE1         = 4'b1000,
    ST_LINE2         = 4'b1001
  } state_t;

  localparam logic [BTN_W-1:0] BTN_UP     = 5'b10000;
  localparam logic [BTN_W-1:0] BTN_DOWN   = 5'b01000;
  localparam logic [BTN_W-1:0] BTN_CENTER = 5'b00100;
  localparam logic [BTN_W-1:0] BTN_LEFT   = 5'b00010;
  localparam logic [BTN_W-1:0] BTN_RIGHT  = 5'b00001;
  localparam logic [BTN_W-1:0] BTN_ALL    = BTN_UP | BTN_DOWN | BTN_CENTER | BTN_LEFT | BTN_RIGHT;

  localparam int unsigned HOUR_MSB = 17;
  localparam int unsigned HOUR_LSB = 12;
  localparam int unsigned MIN_MSB  = 11;
  localparam int unsigned MIN_LSB  = 6;
  localparam int unsigned SEC_MSB  = 5;
  localparam int unsigned SEC_LSB  = 0;

  localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;
  localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;

  typedef struct packed {
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
  } hms_t;

  function automatic logic hms_valid(hms_t t);
    return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

endpackage

// File: rtl/clock_mode_controller_if.sv
// Bus between the mode controller (master) and the LCD driver / editors / button front end (slave).
interface clock_mode_controller_if;
  import clock_pkg::*;

  logic [BTN_W-1:0]   BUTTONS;
  logic               TICK_1HZ;
  logic               LCD_DONE;
  logic               TIME_SET_FLAG;
  logic [TIME_W-1:0]  TIME_SETDATA;
  logic               TZ_SET_FLAG;
  logic [STATE_W-1:0] STATE;
  logic               MENU_SEL;
  logic [TIME_W-1:0]  CLOCK_DATA;
  logic               LOAD_REJECT;

  modport master (
    input  BUTTONS, TICK_1HZ, LCD_DONE, TIME_SET_FLAG, TIME_SETDATA, TZ_SET_FLAG,
    output STATE, MENU_SEL, CLOCK_DATA, LOAD_REJECT
  );

  modport slave (
    output BUTTONS, TICK_1HZ, LCD_DONE, TIME_SET_FLAG, TIME_SETDATA, TZ_SET_FLAG,
    input  STATE, MENU_SEL, CLOCK_DATA, LOAD_REJECT
  );

endinterface

// File: rtl/time_counter.sv
// Running hh:mm:ss register: 1 Hz advance with carries, range-checked load that overrides the tick.
module time_counter
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic load,
  input  hms_t load_data,
  output hms_t time_q,
  output logic reject
);

  hms_t time_inc;
  logic load_ok;

  assign load_ok = hms_valid(load_data);

  // Next second with sec->min->hour carries; >= keeps the wrap robust.
  always_comb begin
    time_inc = time_q;
    if (time_q.sec >= SEC_MAX) begin
      time_inc.sec = '0;
      if (time_q.min >= MIN_MAX) begin
        time_inc.min = '0;
        if (time_q.hour >= HOUR_MAX) time_inc.hour = '0;
        else                         time_inc.hour = time_q.hour + FIELD_W'(1);
      end else begin
        time_inc.min = time_q.min + FIELD_W'(1);
      end
    end else begin
      time_inc.sec = time_q.sec + FIELD_W'(1);
    end
  end

  // A commit, accepted or not, swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= '0;
      reject <= 1'b0;
    end else begin
      reject <= load && !load_ok;
      if (load) begin
        if (load_ok) time_q <= load_data;
      end else if (tick) begin
        time_q <= time_inc;
      end
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the digital clock: LCD init/display loop, setup menu, time commit and press detection.
module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int unsigned INIT_DELAY_CYCLES = 1500000,
  parameter int unsigned MENU_TIMEOUT_S    = 30
) (
  input logic                    CLK,
  input logic                    RESET,
  clock_mode_controller_if.master bus
);

  localparam int unsigned DELAY_W = $clog2(INIT_DELAY_CYCLES + 1);
  localparam int unsigned TMO_W   = $clog2(MENU_TIMEOUT_S + 1);

  state_t             state_q, state_n;
  logic [DELAY_W-1:0] delay_q, delay_n;
  logic [TMO_W-1:0]   tmo_q, tmo_n;
  logic               pending_q, pending_n;
  logic               sel_q, sel_n;
  logic [BTN_W-1:0]   buttons_prev;
  logic [BTN_W-1:0]   press;
  logic               commit;
  hms_t               load_data;
  hms_t               clock_time;
  logic               reject;

  assign press  = bus.BUTTONS & ~buttons_prev;
  assign commit = (state_q == ST_TIME_SET) && bus.TIME_SET_FLAG;

  assign load_data.hour = bus.TIME_SETDATA[HOUR_MSB:HOUR_LSB];
  assign load_data.min  = bus.TIME_SETDATA[MIN_MSB:MIN_LSB];
  assign load_data.sec  = bus.TIME_SETDATA[SEC_MSB:SEC_LSB];

  time_counter u_time (
    .clk       (CLK),
    .rst       (RESET),
    .tick      (bus.TICK_1HZ),
    .load      (commit),
    .load_data (load_data),
    .time_q    (clock_time),
    .reject    (reject)
  );

  // Buttons reset as "all held" so a level present through reset never reads as a press.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_INITIAL_DELAY;
      delay_q      <= '0;
      tmo_q        <= '0;
      pending_q    <= 1'b0;
      sel_q        <= 1'b0;
      buttons_prev <= BTN_ALL;
    end else begin
      state_q      <= state_n;
      delay_q      <= delay_n;
      tmo_q        <= tmo_n;
      pending_q    <= pending_n;
      sel_q        <= sel_n;
      buttons_prev <= bus.BUTTONS;
    end
  end

  always_comb begin
    state_n   = state_q;
    delay_n   = delay_q;
    tmo_n     = '0;
    pending_n = pending_q;
    sel_n     = sel_q;

    case (state_q)
      ST_INITIAL_DELAY: begin
        if (delay_q == DELAY_W'(INIT_DELAY_CYCLES - 1)) begin
          state_n = ST_FUNCTION_SET;
          delay_n = '0;
        end else begin
          delay_n = delay_q + DELAY_W'(1);
        end
      end
      ST_FUNCTION_SET:  if (bus.LCD_DONE) state_n = ST_INITIAL_SETUP;
      ST_INITIAL_SETUP: if (bus.LCD_DONE) state_n = ST_CLEAR_SCREEN;
      ST_CLEAR_SCREEN:  if (bus.LCD_DONE) state_n = ST_LINE1;

      // A menu request waits for the in-flight LCD command to finish.
      ST_LINE1, ST_LINE2: begin
        if (bus.LCD_DONE && pending_q) begin
          state_n   = ST_SETUP;
          pending_n = 1'b0;
          sel_n     = 1'b0;
        end else begin
          if (bus.LCD_DONE) state_n = (state_q == ST_LINE1) ? ST_LINE2 : ST_LINE1;
          if (press == BTN_CENTER) pending_n = 1'b1;
        end
      end

      ST_SETUP: begin
        tmo_n = tmo_q;
        if (press != '0) begin
          tmo_n = '0;
          case (press)
            BTN_UP, BTN_DOWN: sel_n   = ~sel_q;
            BTN_CENTER:       state_n = sel_q ? ST_TZ_SET : ST_TIME_SET;
            BTN_LEFT:         state_n = ST_LINE1;
            default:          ;
          endcase
        end else if (bus.TICK_1HZ) begin
          if (tmo_q == TMO_W'(MENU_TIMEOUT_S - 1)) state_n = ST_LINE1;
          else                                     tmo_n   = tmo_q + TMO_W'(1);
        end
      end

      ST_TIME_SET: if (bus.TIME_SET_FLAG) state_n = ST_LINE1;
      ST_TZ_SET:   if (bus.TZ_SET_FLAG)   state_n = ST_LINE1;
      default:     state_n = ST_INITIAL_DELAY;
    endcase
  end

  assign bus.STATE       = state_q;
  assign bus.MENU_SEL    = sel_q;
  assign bus.CLOCK_DATA  = clock_time;
  assign bus.LOAD_REJECT = reject;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller: directed vector table, then random traffic against a reference model.
module tb_clock_mode_controller;

  localparam int unsigned DLY = 10;
  localparam int unsigned TMO = 30;

  localparam logic [4:0] B0   = 5'b00000;
  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_DN = 5'b01000;
  localparam logic [4:0] B_C  = 5'b00100;
  localparam logic [4:0] B_L  = 5'b00010;
  localparam logic [4:0] B_R  = 5'b00001;

  localparam logic [3:0] S_DLY = 4'b0000;
  localparam logic [3:0] S_FS  = 4'b0001;
  localparam logic [3:0] S_IS  = 4'b0010;
  localparam logic [3:0] S_CS  = 4'b0011;
  localparam logic [3:0] S_SET = 4'b0100;
  localparam logic [3:0] S_TS  = 4'b0101;
  localparam logic [3:0] S_TZ  = 4'b0110;
  localparam logic [3:0] S_L1  = 4'b1000;
  localparam logic [3:0] S_L2  = 4'b1001;

  logic clk = 1'b0;
  logic rst;

  clock_mode_controller_if bus ();

  clock_mode_controller #(
    .INIT_DELAY_CYCLES (DLY),
    .MENU_TIMEOUT_S    (TMO)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  btn;
    logic        tick;
    logic        done;
    logic        tflag;
    logic [17:0] tdata;
    logic        zflag;
    logic [3:0]  e_state;
    logic        e_sel;
    logic [17:0] e_clock;
    logic        e_rej;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [3:0] m_mode;
  logic       m_sel;
  int         m_secs;
  logic       m_rej;
  logic [4:0] m_prev;
  logic       m_pend;
  int         m_wait;
  int         m_idle;

  function automatic logic [17:0] hms(int h, int m, int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [17:0] from_secs(int t);
    return hms(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  task automatic add(input logic r, input logic [4:0] b, input logic tk, input logic dn,
                     input logic tf, input logic [17:0] td, input logic zf,
                     input logic [3:0] es, input logic esel, input logic [17:0] ec, input logic er);
    vec_t v;
    v.rst = r; v.btn = b; v.tick = tk; v.done = dn; v.tflag = tf; v.tdata = td; v.zflag = zf;
    v.e_state = es; v.e_sel = esel; v.e_clock = ec; v.e_rej = er;
    vecs.push_back(v);
  endtask

  task automatic addi(input logic [4:0] b, input logic tk, input logic dn,
                      input logic [3:0] es, input logic esel, input logic [17:0] ec, input logic er);
    add('0, b, tk, dn, '0, '0, '0, es, esel, ec, er);
  endtask

  // CENTER in LINE1, LCD_DONE into SETUP (cursor on time), CENTER into TIME_SET.
  task automatic to_time_set(input logic [17:0] ec, input logic sel_before);
    addi(B_C, '0, '0, S_L1, sel_before, ec, '0);
    addi(B0,  '0, '1, S_SET, '0, ec, '0);
    addi(B_C, '0, '0, S_TS,  '0, ec, '0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] b, input logic tk, input logic dn,
                       input logic tf, input logic [17:0] td, input logic zf);
    rst                = r;
    bus.BUTTONS        = b;
    bus.TICK_1HZ       = tk;
    bus.LCD_DONE       = dn;
    bus.TIME_SET_FLAG  = tf;
    bus.TIME_SETDATA   = td;
    bus.TZ_SET_FLAG    = zf;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic [4:0] b, input logic tk, input logic dn,
                            input logic tf, input logic [17:0] td, input logic zf);
    logic [4:0] p;
    int h, mi, s;
    if (r) begin
      m_mode = S_DLY; m_sel = 1'b0; m_secs = 0; m_rej = 1'b0;
      m_prev = 5'b11111; m_pend = 1'b0; m_wait = 0; m_idle = 0;
      return;
    end
    p      = b & ~m_prev;
    m_prev = b;
    h  = int'(td[17:12]);
    mi = int'(td[11:6]);
    s  = int'(td[5:0]);
    m_rej = 1'b0;
    if (m_mode == S_TS && tf) begin
      if (h < 24 && mi < 60 && s < 60) m_secs = h * 3600 + mi * 60 + s;
      else                             m_rej  = 1'b1;
    end else if (tk) begin
      m_secs = (m_secs + 1) % 86400;
    end
    case (m_mode)
      S_DLY: begin
        m_wait++;
        if (m_wait == int'(DLY)) m_mode = S_FS;
      end
      S_FS: if (dn) m_mode = S_IS;
      S_IS: if (dn) m_mode = S_CS;
      S_CS: if (dn) m_mode = S_L1;
      S_L1, S_L2: begin
        if (dn && m_pend) begin
          m_mode = S_SET; m_pend = 1'b0; m_sel = 1'b0; m_idle = 0;
        end else begin
          if (dn) m_mode = (m_mode == S_L1) ? S_L2 : S_L1;
          if (p == B_C) m_pend = 1'b1;
        end
      end
      S_SET: begin
        if (p != B0) begin
          m_idle = 0;
          if (p == B_UP || p == B_DN) m_sel  = ~m_sel;
          else if (p == B_C)          m_mode = m_sel ? S_TZ : S_TS;
          else if (p == B_L)          m_mode = S_L1;
        end else if (tk) begin
          m_idle++;
          if (m_idle == int'(TMO)) m_mode = S_L1;
        end
      end
      S_TS: if (tf) m_mode = S_L1;
      S_TZ: if (zf) m_mode = S_L1;
      default: m_mode = S_DLY;
    endcase
  endtask

  initial begin
    vec_t v;
    int   t;
    logic [17:0] tt;

    // Reset and init sequence
    add('1, B0, '0, '0, '0, '0, '0, S_DLY, '0, '0, '0);
    for (int i = 0; i < 9; i++) addi(B0, '0, '0, S_DLY, '0, '0, '0);
    addi(B0, '0, '0, S_FS, '0, '0, '0);
    addi(B0, '0, '1, S_IS, '0, '0, '0);
    addi(B0, '0, '1, S_CS, '0, '0, '0);
    addi(B0, '0, '1, S_L1, '0, '0, '0);
    // Menu entry deferred to LCD_DONE, then timezone path
    addi(B_C, '0, '0, S_L1, '0, '0, '0);
    addi(B0,  '0, '1, S_SET, '0, '0, '0);
    addi(B_DN, '0, '0, S_SET, '1, '0, '0);
    addi(B0,  '0, '0, S_SET, '1, '0, '0);
    addi(B_C, '0, '0, S_TZ, '1, '0, '0);
    add('0, B0, '0, '0, '0, '0, '1, S_L1, '1, '0, '0);
    // Midnight wrap and hour carry
    to_time_set('0, '1);
    add('0, B0, '0, '0, '1, hms(23, 59, 59), '0, S_L1, '0, hms(23, 59, 59), '0);
    addi(B0, '1, '0, S_L1, '0, hms(0, 0, 0), '0);
    to_time_set('0, '0);
    add('0, B0, '0, '0, '1, hms(0, 59, 59), '0, S_L1, '0, hms(0, 59, 59), '0);
    addi(B0, '1, '0, S_L1, '0, hms(1, 0, 0), '0);
    // Commit beats a coincident tick
    to_time_set(hms(1, 0, 0), '0);
    add('0, B0, '1, '0, '1, hms(12, 34, 56), '0, S_L1, '0, hms(12, 34, 56), '0);
    tt = hms(12, 34, 56);
    // Out-of-range commits
    to_time_set(tt, '0);
    add('0, B0, '0, '0, '1, hms(24, 0, 0), '0, S_L1, '0, tt, '1);
    addi(B0, '0, '0, S_L1, '0, tt, '0);
    to_time_set(tt, '0);
    add('0, B0, '0, '0, '1, hms(5, 60, 0), '0, S_L1, '0, tt, '1);
    addi(B0, '0, '0, S_L1, '0, tt, '0);
    // Flags outside their state, display loop
    add('0, B0, '0, '0, '1, hms(1, 2, 3), '0, S_L1, '0, tt, '0);
    addi(B0, '0, '1, S_L2, '0, tt, '0);
    addi(B0, '0, '1, S_L1, '0, tt, '0);
    // SETUP: multi-button ignored, stray LCD_DONE/flags ignored, UP toggles, LEFT cancels
    addi(B_C, '0, '0, S_L1, '0, tt, '0);
    addi(B0,  '0, '1, S_SET, '0, tt, '0);
    addi(B_UP | B_DN, '0, '0, S_SET, '0, tt, '0);
    addi(B0, '0, '0, S_SET, '0, tt, '0);
    addi(B0, '0, '1, S_SET, '0, tt, '0);
    add('0, B0, '0, '0, '0, '0, '1, S_SET, '0, tt, '0);
    add('0, B0, '0, '0, '1, hms(1, 1, 1), '0, S_SET, '0, tt, '0);
    addi(B_UP, '0, '0, S_SET, '1, tt, '0);
    addi(B0,   '0, '0, S_SET, '1, tt, '0);
    addi(B_L,  '0, '0, S_L1,  '1, tt, '0);
    // Timeout, restarted by a RIGHT press after 20 ticks
    t = 12 * 3600 + 34 * 60 + 56;
    addi(B_C, '0, '0, S_L1, '1, tt, '0);
    addi(B0,  '0, '1, S_SET, '0, tt, '0);
    for (int i = 0; i < 20; i++) begin
      t++;
      addi(B0, '1, '0, S_SET, '0, from_secs(t), '0);
    end
    addi(B_R, '0, '0, S_SET, '0, from_secs(t), '0);
    for (int i = 0; i < 29; i++) begin
      t++;
      addi(B0, '1, '0, S_SET, '0, from_secs(t), '0);
    end
    t++;
    addi(B0, '1, '0, S_L1, '0, from_secs(t), '0);
    // CENTER held through reset never requests the menu
    add('1, B_C, '0, '0, '0, '0, '0, S_DLY, '0, '0, '0);
    for (int i = 0; i < 9; i++) addi(B_C, '0, '0, S_DLY, '0, '0, '0);
    addi(B_C, '0, '0, S_FS, '0, '0, '0);
    addi(B_C, '0, '1, S_IS, '0, '0, '0);
    addi(B_C, '0, '1, S_CS, '0, '0, '0);
    addi(B_C, '0, '1, S_L1, '0, '0, '0);
    addi(B_C, '0, '1, S_L2, '0, '0, '0);
    addi(B_C, '0, '1, S_L1, '0, '0, '0);

    drive('1, B0, '0, '0, '0, '0, '0);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.btn, v.tick, v.done, v.tflag, v.tdata, v.zflag);
      cycle();
      check($sformatf("vec%0d STATE", i),       32'(bus.STATE),       32'(v.e_state));
      check($sformatf("vec%0d MENU_SEL", i),    32'(bus.MENU_SEL),    32'(v.e_sel));
      check($sformatf("vec%0d CLOCK_DATA", i),  32'(bus.CLOCK_DATA),  32'(v.e_clock));
      check($sformatf("vec%0d LOAD_REJECT", i), 32'(bus.LOAD_REJECT), 32'(v.e_rej));
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, tk, dn, tf, zf;
      logic [4:0]  b;
      logic [17:0] td;
      int          sel;
      r   = (i == 0) || ($urandom_range(0, 599) == 0);
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      b = B0;
      else if (sel < 9) b = 5'(1 << $urandom_range(0, 4));
      else              b = 5'($urandom);
      tk = ($urandom_range(0, 7) == 0);
      dn = ($urandom_range(0, 3) == 0);
      tf = ($urandom_range(0, 5) == 0);
      zf = ($urandom_range(0, 5) == 0);
      td = hms(int'($urandom_range(0, 25)), int'($urandom_range(0, 61)), int'($urandom_range(0, 61)));
      drive(r, b, tk, dn, tf, td, zf);
      model_step(r, b, tk, dn, tf, td, zf);
      cycle();
      check($sformatf("rnd%0d STATE", i),       32'(bus.STATE),       32'(m_mode));
      check($sformatf("rnd%0d MENU_SEL", i),    32'(bus.MENU_SEL),    32'(m_sel));
      check($sformatf("rnd%0d CLOCK_DATA", i),  32'(bus.CLOCK_DATA),  32'(from_secs(m_secs)));
      check($sformatf("rnd%0d LOAD_REJECT", i), 32'(bus.LOAD_REJECT), 32'(m_rej));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
